fp_wb_queue: RTL and testbench

Writeback buffer between the iterative FP divide/sqrt unit and write port x of the two-write-port FP register file. Long-latency results are accepted with a valid/ready handshake, held in a small FIFO and drained in order onto port x whenever the load writeback path is not using that port. A per-register pending vector lets decode interlock RAW/WAW hazards against queued results.

---
 rtl/fp_wb_queue.sv | 111 +++++++++++
 tb/tb_fp_wb_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_queue.sv
// Writeback FIFO between the FP divide/sqrt unit and register-file write port x.
// Optional macro FP_WB_BYPASS_EN: an empty queue forwards a result straight to port x.
module fp_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_wn,
    input  logic [31:0]              in_d,
    input  logic                     ld_we,
    input  logic [4:0]               ld_wn,
    input  logic [31:0]              ld_d,
    output logic                     wex,
    output logic [4:0]               wnx,
    output logic [31:0]              dx,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_wn_mem [DEPTH];
    logic [31:0]    r_d_mem  [DEPTH];

    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [31:0]    w_onehot [DEPTH];
    logic [31:0]    w_busy;

`ifdef FP_WB_BYPASS_EN
    assign w_bypass = (r_cnt == '0) & ~ld_we & in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready = (r_cnt != CW'(DEPTH));
    assign w_push   = in_valid & in_ready & ~w_bypass;
    // The load path owns port x whenever it asks; the queue simply waits.
    assign w_pop    = ~ld_we & (r_cnt != '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + AW'(1);
            if (w_pop)
                r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wn_mem[r_tail] <= in_wn;
            r_d_mem[r_tail]  <= in_d;
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] w_off;
            assign w_off        = AW'(gi) - r_head;
            assign w_valid[gi]  = ({1'b0, w_off} < r_cnt);
            assign w_onehot[gi] = w_valid[gi] ? (32'd1 << r_wn_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++)
            w_busy = w_busy | w_onehot[i];
    end

    assign busy = w_busy;
    assign cnt  = r_cnt;

    always_comb begin
        wex = 1'b0;
        wnx = '0;
        dx  = '0;
        if (ld_we) begin
            wex = 1'b1;
            wnx = ld_wn;
            dx  = ld_d;
        end else if (r_cnt != '0) begin
            wex = 1'b1;
            wnx = r_wn_mem[r_head];
            dx  = r_d_mem[r_head];
        end else if (w_bypass) begin
            wex = 1'b1;
            wnx = in_wn;
            dx  = in_d;
        end
    end

endmodule

// File: tb/tb_fp_wb_queue.sv
// Self-checking bench for fp_wb_queue: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fp_wb_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clrn;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_wn;
    logic [31:0]   in_d;
    logic          ld_we;
    logic [4:0]    ld_wn;
    logic [31:0]   ld_d;
    logic          wex;
    logic [4:0]    wnx;
    logic [31:0]   dx;
    logic [31:0]   busy;
    logic [CW-1:0] cnt;

    fp_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready), .in_wn(in_wn), .in_d(in_d),
        .ld_we(ld_we), .ld_wn(ld_wn), .ld_d(ld_d),
        .wex(wex), .wnx(wnx), .dx(dx), .busy(busy), .cnt(cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [36:0] mq[$];   // reference queue of {wn, d}

    typedef struct {
        logic        v;
        logic [4:0]  wn;
        logic [31:0] d;
        logic        lwe;
        logic [4:0]  lwn;
        logic [31:0] ldd;
        logic        e_ready;
        logic        e_wex;
        logic [4:0]  e_wnx;
        logic [31:0] e_dx;
        logic [31:0] e_busy;
        int          e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [4:0] wn, input logic [31:0] d,
                         input logic lwe, input logic [4:0] lwn, input logic [31:0] ldd);
        in_valid = v; in_wn = wn; in_d = d;
        ld_we = lwe; ld_wn = lwn; ld_d = ldd;
    endtask

    function automatic logic model_bypass();
`ifdef FP_WB_BYPASS_EN
        return (mq.size() == 0) && !ld_we && in_valid;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic        e_wex;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        logic [31:0] e_busy;
        e_wex = 1'b0; e_wn = '0; e_d = '0; e_busy = '0;
        foreach (mq[i]) e_busy[mq[i][36:32]] = 1'b1;
        if (ld_we) begin
            e_wex = 1'b1; e_wn = ld_wn; e_d = ld_d;
        end else if (mq.size() > 0) begin
            e_wex = 1'b1; e_wn = mq[0][36:32]; e_d = mq[0][31:0];
        end else if (model_bypass()) begin
            e_wex = 1'b1; e_wn = in_wn; e_d = in_d;
        end
        chk({tag, ".wex"}, 32'(wex), 32'(e_wex));
        chk({tag, ".wnx"}, 32'(wnx), 32'(e_wn));
        chk({tag, ".dx"}, dx, e_d);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".cnt"}, 32'(cnt), 32'(mq.size()));
        chk({tag, ".ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
    endtask

    // Compares current outputs to the model, then steps one clock edge.
    task automatic advance(input string tag, output logic acc);
        logic pop;
        check_model(tag);
        acc = in_valid && (mq.size() < DEPTH) && !model_bypass();
        pop = !ld_we && (mq.size() > 0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({in_wn, in_d});
        @(negedge clk);
        $display("[%0t] %s v=%0b wn=%0d acc=%0b ld_we=%0b cnt=%0d", $time, tag, in_valid, in_wn, acc, ld_we, mq.size());
    endtask

    task automatic drain(input string tag);
        logic acc;
        int   budget = 20;
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        while (mq.size() > 0 && budget > 0) begin
            #1; advance(tag, acc);
            budget--;
        end
        chk({tag, ".drained"}, 32'(mq.size()), 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        logic acc;
        int   idx;
        int   budget;
        logic pv;
        logic [4:0]  pwn;
        logic [31:0] pd;

        // Reset state; port x still follows the load path during reset.
        clrn = 1'b0;
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("rst.cnt", 32'(cnt), 32'd0);
        chk("rst.busy", busy, 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.wex", 32'(wex), 32'd0);
        chk("rst.dx", dx, 32'd0);
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hCAFE0001);
        #1;
        chk("rst.ld_wex", 32'(wex), 32'd1);
        chk("rst.ld_wnx", 32'(wnx), 32'd4);
        chk("rst.ld_dx", dx, 32'hCAFE0001);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        clrn = 1'b1;

`ifndef FP_WB_BYPASS_EN
        //          v  wn     d              lwe lwn    ldd            rdy wex wnx    dx             busy          cnt
        tbl[0]  = '{1, 5'd5, 32'h3F800000, 0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        tbl[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 1, 5'd5, 32'h3F800000,  32'h20,        1};
        tbl[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        tbl[3]  = '{1, 5'd3, 32'h11,       0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        tbl[4]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'hAA,        1, 1, 5'd7, 32'hAA,        32'h8,         1};
        tbl[5]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'hAA,        1, 1, 5'd7, 32'hAA,        32'h8,         1};
        tbl[6]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'hAA,        1, 1, 5'd7, 32'hAA,        32'h8,         1};
        tbl[7]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 1, 5'd3, 32'h11,        32'h8,         1};
        tbl[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        tbl[9]  = '{1, 5'd9, 32'h1,        0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        tbl[10] = '{1, 5'd9, 32'h2,        1, 5'd1, 32'h55,        1, 1, 5'd1, 32'h55,        32'h200,       1};
        tbl[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 1, 5'd9, 32'h1,         32'h200,       2};
        tbl[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 1, 5'd9, 32'h2,         32'h200,       1};
        tbl[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 0, 5'd0, 32'h0,         32'h0,         0};
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].v, tbl[i].wn, tbl[i].d, tbl[i].lwe, tbl[i].lwn, tbl[i].ldd);
            #1;
            chk($sformatf("tbl%0d.ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.wex", i), 32'(wex), 32'(tbl[i].e_wex));
            chk($sformatf("tbl%0d.wnx", i), 32'(wnx), 32'(tbl[i].e_wnx));
            chk($sformatf("tbl%0d.dx", i), dx, tbl[i].e_dx);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d.cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
            advance($sformatf("tbl%0d", i), acc);
        end
`endif

        // Fill while the load path holds port x; fifth result must wait.
        idx = 1;
        budget = 30;
        while (idx <= 4 && budget > 0) begin
            apply(1'b1, 5'(idx), 32'h100 + 32'(idx), 1'b1, 5'd30, 32'hBEEF);
            #1; advance("fill", acc);
            if (acc) idx++;
            budget--;
        end
        chk("fill.accepted", 32'(idx), 32'd5);
        apply(1'b1, 5'd5, 32'h105, 1'b1, 5'd30, 32'hBEEF);
        #1;
        chk("fill.ready_low", 32'(in_ready), 32'd0);
        chk("fill.cnt_full", 32'(cnt), 32'(DEPTH));
        advance("fill_hold", acc);
        chk("fill.held", 32'(acc), 32'd0);
        budget = 10;
        acc = 1'b0;
        while (!acc && budget > 0) begin
            apply(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0);
            #1; advance("fill_rel", acc);
            budget--;
        end
        chk("fill.fifth_accepted", 32'(acc), 32'd1);
        drain("fill_drain");

        // Back-to-back pushes across the pointer wrap.
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 5'(k), 32'h200 + 32'(k), 1'b0, 5'd0, 32'h0);
            #1; advance("wrap", acc);
            chk("wrap.acc", 32'(acc), 32'd1);
            chk("wrap.cnt_le1", 32'(cnt <= 1), 32'd1);
        end
        drain("wrap_drain");

        // Randomized traffic; a refused result is held until accepted.
        pv = 1'b0; pwn = '0; pd = '0;
        for (int k = 0; k < 400; k++) begin
            logic lwe;
            if (!pv && ($urandom_range(0, 99) < 60)) begin
                pv = 1'b1; pwn = 5'($urandom_range(0, 31)); pd = $urandom;
            end
            lwe = ($urandom_range(0, 99) < 35);
            apply(pv, pwn, pd, lwe, 5'($urandom_range(0, 31)), $urandom);
            #1; advance("rand", acc);
            if (acc) pv = 1'b0;
        end
        drain("rand_drain");

        // Asynchronous reset with three queued entries.
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 5'(10 + k), 32'h300 + 32'(k), 1'b1, 5'd31, 32'h0);
            #1; advance("prerst", acc);
        end
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        clrn = 1'b0;
        mq.delete();
        #1;
        chk("arst.cnt", 32'(cnt), 32'd0);
        chk("arst.busy", busy, 32'd0);
        chk("arst.ready", 32'(in_ready), 32'd1);
        chk("arst.wex", 32'(wex), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; advance("postrst", acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
